// File: rtl/calc_entrada_teclado.sv
// calc_entrada_teclado
// Keypad entry front-end for the calculator. It synchronises the scanner's
// `ready` level, turns each press into a single key event, and assembles two
// BCD operands and an operator. It then pulses `start` to the arithmetic
// unit, latches the returned result, and drives the display value.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   tecla, ready      key code and key-held level from the scanner
//   resultado         BCD result from the arithmetic unit
//   resultado_valido  one-cycle strobe qualifying `resultado`
//   operando_a/_b     BCD operands, least significant digit in [3:0]
//   operacao          operator: 00 add, 01 sub, 10 mul, 11 div
//   start             one-cycle computation request
//   display           registered BCD value for the 7-segment displays
//   estado            FSM state: 00 ENT_A, 01 ENT_B, 10 RESULT
module calc_entrada_teclado #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          tecla,
  input  logic                ready,
  input  logic [4*DIGITS-1:0] resultado,
  input  logic                resultado_valido,
  output logic [4*DIGITS-1:0] operando_a,
  output logic [4*DIGITS-1:0] operando_b,
  output logic [1:0]          operacao,
  output logic                start,
  output logic [4*DIGITS-1:0] display,
  output logic [1:0]          estado
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENT_A  = 2'b00,
    ENT_B  = 2'b01,
    RESULT = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic           r1_q, r1_d, r2_q, r2_d, rp_q, rp_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, display_q, display_d;
  logic [CW-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]     op_q, op_d;
  logic           start_q, start_d;

  logic           ev;
  logic           is_digit, is_op, is_eq, is_clr;
  logic [1:0]     key_op;
  logic [W-1:0]   res_eff;

  function automatic logic [W-1:0] shift_in(input logic [W-1:0] x,
                                            input logic [3:0]   d);
    return {x[W-5:0], d};
  endfunction

  // Synchroniser plus history register. The history register makes the
  // event a rising-edge detect, so one press gives exactly one event.
  always_comb begin
    r1_d = ready;
    r2_d = r1_q;
    rp_d = r2_q;
  end

  assign ev = r2_q & ~rp_q;

  always_comb begin
    is_digit = (tecla <= 4'd9);
    is_eq    = (tecla == 4'hE);
    is_clr   = (tecla == 4'hF);
    is_op    = 1'b0;
    key_op   = 2'b00;
    case (tecla)
      4'hA: begin is_op = 1'b1; key_op = 2'b00; end
      4'hB: begin is_op = 1'b1; key_op = 2'b01; end
      4'hC: begin is_op = 1'b1; key_op = 2'b10; end
      4'hD: begin is_op = 1'b1; key_op = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    start_d = 1'b0;

    // A strobe coinciding with a key event in RESULT is latched first, so an
    // operator key chains the freshly arrived result.
    res_eff = (state_q == RESULT && resultado_valido) ? resultado : res_q;
    res_d   = res_eff;

    if (ev) begin
      if (is_clr) begin
        state_d = ENT_A;
        a_d     = '0;
        b_d     = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        op_d    = 2'b00;
        res_d   = '0;
      end else begin
        unique case (state_q)
          ENT_A: begin
            if (is_digit) begin
              if (cnt_a_q != CNT_MAX) begin
                a_d     = shift_in(a_q, tecla);
                cnt_a_d = cnt_a_q + CW'(1);
              end
            end else if (is_op) begin
              op_d    = key_op;
              b_d     = '0;
              cnt_b_d = '0;
              state_d = ENT_B;
            end
          end
          ENT_B: begin
            if (is_digit) begin
              if (cnt_b_q != CNT_MAX) begin
                b_d     = shift_in(b_q, tecla);
                cnt_b_d = cnt_b_q + CW'(1);
              end
            end else if (is_op) begin
              if (cnt_b_q == '0) op_d = key_op;
            end else if (is_eq && cnt_b_q != '0) begin
              start_d = 1'b1;
              state_d = RESULT;
            end
          end
          RESULT: begin
            if (is_digit) begin
              a_d     = {{(W-4){1'b0}}, tecla};
              cnt_a_d = CW'(1);
              b_d     = '0;
              cnt_b_d = '0;
              res_d   = '0;
              state_d = ENT_A;
            end else if (is_op) begin
              a_d     = res_eff;
              cnt_a_d = CNT_MAX;
              b_d     = '0;
              cnt_b_d = '0;
              op_d    = key_op;
              state_d = ENT_B;
            end
          end
          default: state_d = ENT_A;
        endcase
      end
    end

    // Display follows the next-state values so it always agrees with the
    // other registered outputs in the same cycle.
    case (state_d)
      ENT_B:   display_d = (cnt_b_d != '0) ? b_d : a_d;
      RESULT:  display_d = res_d;
      default: display_d = a_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ENT_A;
      r1_q      <= 1'b0;
      r2_q      <= 1'b0;
      rp_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      display_q <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      op_q      <= 2'b00;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      rp_q      <= rp_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      display_q <= display_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      op_q      <= op_d;
      start_q   <= start_d;
    end
  end

  assign operando_a = a_q;
  assign operando_b = b_q;
  assign operacao   = op_q;
  assign start      = start_q;
  assign display    = display_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_calc_entrada_teclado.sv
module tb_calc_entrada_teclado;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   tecla;
  logic         ready;
  logic [W-1:0] resultado;
  logic         resultado_valido;
  logic [W-1:0] operando_a, operando_b, display;
  logic [1:0]   operacao, estado;
  logic         start;

  calc_entrada_teclado #(.DIGITS(DIGITS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tecla            (tecla),
    .ready            (ready),
    .resultado        (resultado),
    .resultado_valido (resultado_valido),
    .operando_a       (operando_a),
    .operando_b       (operando_b),
    .operacao         (operacao),
    .start            (start),
    .display          (display),
    .estado           (estado)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: operands kept as lists of entered digits, state as an
  // integer (0 ENT_A, 1 ENT_B, 2 RESULT).
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } txn_t;

  txn_t         exp_q[$];
  int           qa[$];
  int           qb[$];
  int           m_state;
  logic [1:0]   m_op;
  logic [W-1:0] m_res;

  function automatic logic [W-1:0] pack_digits(input bit which_b);
    logic [W-1:0] v;
    v = '0;
    if (which_b) for (int i = 0; i < qb.size(); i++) v = (v << 4) | W'(qb[i]);
    else         for (int i = 0; i < qa.size(); i++) v = (v << 4) | W'(qa[i]);
    return v;
  endfunction

  function automatic logic [W-1:0] model_display();
    if (m_state == 2) return m_res;
    if (m_state == 1 && qb.size() > 0) return pack_digits(1'b1);
    return pack_digits(1'b0);
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_state = 0;
    m_op    = 2'b00;
    m_res   = '0;
  endtask

  task automatic model_key(input int k);
    txn_t t;
    if (k == 15) begin
      model_reset();
    end else if (m_state == 0) begin
      if (k <= 9) begin
        if (qa.size() < DIGITS) qa.push_back(k);
      end else if (k <= 13) begin
        m_op = 2'(k - 10);
        qb.delete();
        m_state = 1;
      end
    end else if (m_state == 1) begin
      if (k <= 9) begin
        if (qb.size() < DIGITS) qb.push_back(k);
      end else if (k <= 13) begin
        if (qb.size() == 0) m_op = 2'(k - 10);
      end else if (qb.size() > 0) begin
        t.a  = pack_digits(1'b0);
        t.b  = pack_digits(1'b1);
        t.op = m_op;
        exp_q.push_back(t);
        m_state = 2;
      end
    end else begin
      if (k <= 9) begin
        qa.delete();
        qa.push_back(k);
        qb.delete();
        m_res   = '0;
        m_state = 0;
      end else if (k <= 13) begin
        qa.delete();
        for (int i = DIGITS - 1; i >= 0; i--) qa.push_back(int'(m_res[4*i +: 4]));
        qb.delete();
        m_op    = 2'(k - 10);
        m_state = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.estado", tag), W'(estado), W'(m_state));
    check($sformatf("%s.operando_a", tag), operando_a, pack_digits(1'b0));
    check($sformatf("%s.operando_b", tag), operando_b, pack_digits(1'b1));
    check($sformatf("%s.operacao", tag), W'(operacao), W'(m_op));
    check($sformatf("%s.display", tag), display, model_display());
    check($sformatf("%s.start", tag), W'(start), '0);
  endtask

  task automatic press(input int k, input int hold, input int gap);
    model_key(k);
    @(negedge clk);
    tecla = 4'(k);
    ready = 1'b1;
    repeat (hold) @(negedge clk);
    ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic strobe(input logic [W-1:0] v);
    if (m_state == 2) m_res = v;
    @(negedge clk);
    resultado        = v;
    resultado_valido = 1'b1;
    @(negedge clk);
    resultado_valido = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Strobe lands in the same cycle as the key event.
  task automatic press_with_strobe(input int k, input logic [W-1:0] v);
    if (m_state == 2) m_res = v;
    model_key(k);
    @(negedge clk);
    tecla = 4'(k);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    resultado        = v;
    resultado_valido = 1'b1;
    @(negedge clk);
    resultado_valido = 1'b0;
    repeat (3) @(negedge clk);
    ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: every start pulse must match the oldest expected transaction.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_unexpected actual=1 expected=0");
        end else begin
          t = exp_q.pop_front();
          check("start.operando_a", operando_a, t.a);
          check("start.operando_b", operando_b, t.b);
          check("start.operacao", W'(operacao), W'(t.op));
          check("start.estado", W'(estado), W'(2));
        end
      end
    end
  end

  initial begin
    int r, k;
    rst_n = 1'b0;
    ready = 1'b0;
    tecla = 4'h0;
    resultado = '0;
    resultado_valido = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 12 + 34 =
    press(1, 10, 10); check_all("k1");
    press(2, 10, 10); check_all("k2");
    press(10, 10, 10); check_all("kplus");
    press(3, 10, 10); check_all("k3");
    press(4, 10, 10); check_all("k4");
    press(14, 10, 10); check_all("keq");

    // result 0x0046 chained into a multiply by 2
    strobe(16'h0046); check_all("res46");
    press(12, 10, 10); check_all("kmul");
    press(2, 10, 10); check_all("k2b");
    press(14, 10, 10); check_all("keq2");

    // long hold yields one digit; then overflow at DIGITS
    press(15, 5, 6); check_all("clr");
    press(7, 1000, 6); check_all("hold7");
    press(15, 5, 6);
    press(9, 4, 5); press(8, 4, 5); press(7, 4, 5); press(6, 4, 5);
    press(5, 4, 5); check_all("overflow");

    // equals without B digits, then clear
    press(11, 4, 5); press(14, 4, 5); check_all("eq_nob");
    press(15, 4, 5); check_all("clr2");

    // asynchronous reset during a held key
    press(5, 4, 5); check_all("a5");
    @(negedge clk);
    tecla = 4'h3;
    ready = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_key(3);
    repeat (20) @(negedge clk);
    ready = 1'b0;
    repeat (5) @(negedge clk);
    check_all("held_after_rst");

    // randomized sequences
    repeat (200) begin
      r = $urandom_range(0, 99);
      if (m_state == 2 && r < 30) begin
        strobe(rand_bcd());
        check_all("rnd_strobe");
      end else if (m_state == 2 && r < 45) begin
        press_with_strobe($urandom_range(0, 1) == 0 ? $urandom_range(0, 9)
                                                    : $urandom_range(10, 13),
                          rand_bcd());
        check_all("rnd_pws");
      end else if (m_state != 2 && r < 8) begin
        strobe(rand_bcd());
        check_all("rnd_ign_strobe");
      end else begin
        r = $urandom_range(0, 99);
        if (r < 55)      k = $urandom_range(0, 9);
        else if (r < 75) k = $urandom_range(10, 13);
        else if (r < 93) k = 14;
        else             k = 15;
        press(k, $urandom_range(1, 12), $urandom_range(4, 10));
        check_all("rnd_key");
      end
    end

    repeat (5) @(negedge clk);
    check("pending_starts", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entrada_teclado.md
Name: calc_entrada_teclado

Overview:
- Consumes the keypad scanner's `tecla`/`ready` outputs.
- Turns each key press into exactly one key event.
- Assembles two BCD operands and an operator, then issues a one-cycle `start` pulse to the arithmetic unit.
- Latches the arithmetic unit's result for display and chaining, and drives the value shown on the 7-segment displays.

Parameters:
- DIGITS, 4, number of BCD digits per operand; operand/display width is 4*DIGITS.

Ports:
- clk  in  1  system clock, the same 50 MHz clock as the scanner.
- rst_n  in  1  asynchronous, active-low reset.
- tecla  in  4  key code from the scanner, registered there.
- ready  in  1  high while a key is held; asynchronous with respect to debounce, so it is synchronised here.
- resultado  in  4*DIGITS  BCD result from the arithmetic unit.
- resultado_valido  in  1  one-cycle strobe: `resultado` is valid.
- operando_a  out  4*DIGITS  BCD operand A; the least significant digit is in [3:0].
- operando_b  out  4*DIGITS  BCD operand B.
- operacao  out  2  operator: 00 add, 01 sub, 10 mul, 11 div.
- start  out  1  one-cycle pulse requesting a computation.
- display  out  4*DIGITS  BCD value to be shown.
- estado  out  2  FSM state: 00 ENT_A, 01 ENT_B, 10 RESULT.

Behaviour:
- Clock and reset: clk is the only clock; rst_n is asynchronous and active-low.
- Reset values: all outputs and internal registers are 0; `estado` = ENT_A.
- Synchroniser: `ready` passes through 2 flip-flops (`r1`, `r2`), followed by a history register `rp`.
- Key event: `ev` = `r2 & ~rp`, so one event per press; holding or releasing a key produces nothing.
- Key capture: `tecla` is sampled in the `ev` cycle. It is stable by then, because the scanner registers `tecla` one cycle after raising `ready`.
- Latency: state and register updates from a key are visible on the 3rd rising clk edge after `ready` is first sampled high.
- Key classes:
  - 0000–1001: digit.
  - 1010/1011/1100/1101 (A/B/C/D): operator, mapped to `operacao` 00/01/10/11.
  - 1110 (#): equals.
  - 1111 (*): clear.
- Digit entry: a digit into X shifts left, X <= {X[4*DIGITS-5:0], d}, and increments `cnt_X`.
- Digit overflow: if `cnt_X` == DIGITS, the digit is ignored and X is unchanged.
- Clear, in any state: `operando_a`, `operando_b`, `operacao`, both counters and the latched result go to 0; state goes to ENT_A. `start` stays 0.
- ENT_A:
  - digit: shifts into A.
  - operator: latches `operacao`, clears B and `cnt_b`, goes to ENT_B. Valid with `cnt_a` = 0, in which case A = 0.
  - equals: ignored.
- ENT_B:
  - digit: shifts into B.
  - operator: overwrites `operacao` only if `cnt_b` = 0, otherwise ignored.
  - equals with `cnt_b` > 0: `start` = 1 for exactly one cycle, concurrent with the state register moving to RESULT.
  - equals with `cnt_b` = 0: ignored.
- `start` timing: `operando_a`/`operando_b`/`operacao` are already stable when `start` is high and remain unchanged while in RESULT.
- RESULT:
  - `resultado_valido` latches `resultado` into `res_q`; a later strobe overwrites it.
  - digit: clears A, B, counters and `res_q`; loads A = d with `cnt_a` = 1; goes to ENT_A.
  - operator: A <= `res_q`, `cnt_a` <= DIGITS; B and `cnt_b` cleared; `operacao` latched; goes to ENT_B.
  - equals: ignored; no second `start`.
- `resultado_valido` outside RESULT: ignored.
- Strobe and key event in the same cycle while in RESULT: the strobe's value is latched first, and the operator uses the new `resultado`.
- `display` (registered):
  - ENT_A: `operando_a`.
  - ENT_B: `operando_b` if `cnt_b` > 0, else `operando_a`.
  - RESULT: `res_q`.
- Reset mid-press: if rst_n is asserted while `ready` is high, the synchronisers clear. The still-held key then produces one event after reset release, which is acceptable.
- Sync registers: the synchroniser and history registers also reset to 0.

Test Plan:
- Reset, then press 1,2,+,3,4,= with `ready` held 10 cycles per press and 10 low between presses → A = 0x0012, B = 0x0034, `operacao` = 00, exactly one `start` pulse, `estado` = RESULT.
- Hold 7 with `ready` high for 1000 cycles → A = 0x0007 and `cnt_a` = 1; no repeated entry.
- With DIGITS = 4, press 9,8,7,6,5 → A = 0x9876; the 5th digit is ignored.
- After `start`, drive `resultado` = 0x0046 with `resultado_valido`; press C,2,= → `display` = 0x0046 before C; then A = 0x0046, `operacao` = 10, B = 0x0002, and a second `start` pulse.
- In ENT_B, press = with no B digits → no `start`; press * → all outputs 0, `estado` = ENT_A.
- Assert rst_n low mid-entry (A = 0x0005) → outputs 0 immediately (asynchronously) and `start` never pulses; after release, a held key yields exactly one event.
